// File: rtl/alu_ctl_pkg.sv
// Shared ALU control encodings and the shift-sequencer state type.
package alu_ctl_pkg;

    // ALU command codes
    localparam logic [2:0] ALU_SHIFT = 3'b001;
    localparam logic [2:0] ALU_NOP   = 3'b111;

    // Shift sub-types. Plain shifts insert a constant fill bit. The _C variants
    // insert sc_in, which chains a shift across two bytes.
    localparam logic [2:0] TS_SL0 = 3'b000;  // left, fill 0
    localparam logic [2:0] TS_SL1 = 3'b001;  // left, fill 1
    localparam logic [2:0] TS_SR0 = 3'b010;  // right, fill 0
    localparam logic [2:0] TS_SR1 = 3'b011;  // right, fill 1
    localparam logic [2:0] TS_SLC = 3'b100;  // left, fill from sc_in
    localparam logic [2:0] TS_SRC = 3'b101;  // right, fill from sc_in
    localparam logic [2:0] TS_ROL = 3'b110;  // rotate left
    localparam logic [2:0] TS_ROR = 3'b111;  // rotate right

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// Byte-wide combinational shift ALU. It sits beside shift_seq and is driven by it.
module alu
    import alu_ctl_pkg::*;
(
    input  logic [2:0] cmd,
    input  logic [2:0] typeselect,
    input  logic [7:0] inA,
    input  logic       sc_in,
    output logic [7:0] rslt,
    output logic       sc_o
);

    // Decode the command and shift type into a result and a carry-out.
    always_comb begin
        rslt = 8'h00;
        sc_o = 1'b0;
        if (cmd == ALU_SHIFT) begin
            case (typeselect)
                TS_SL0:  begin rslt = {inA[6:0], 1'b0};   sc_o = inA[7]; end
                TS_SL1:  begin rslt = {inA[6:0], 1'b1};   sc_o = inA[7]; end
                TS_SR0:  begin rslt = {1'b0, inA[7:1]};   sc_o = inA[0]; end
                TS_SR1:  begin rslt = {1'b1, inA[7:1]};   sc_o = inA[0]; end
                TS_SLC:  begin rslt = {inA[6:0], sc_in};  sc_o = inA[7]; end
                TS_SRC:  begin rslt = {sc_in, inA[7:1]};  sc_o = inA[0]; end
                TS_ROL:  begin rslt = {inA[6:0], inA[7]}; sc_o = inA[7]; end
                TS_ROR:  begin rslt = {inA[0], inA[7:1]}; sc_o = inA[0]; end
                default: begin rslt = 8'h00;              sc_o = 1'b0;   end
            endcase
        end else begin
            rslt = 8'h00;
            sc_o = 1'b0;
        end
    end

endmodule

// File: rtl/shift_seq.sv
// 16-bit multi-position shifter built on an external 8-bit shift ALU.
// Each bit position takes two cycles. FIRST shifts the byte that receives
// the fill bit. SECOND shifts the other byte, taking the first byte's carry
// as its fill, so the bit crosses the byte boundary.
module shift_seq
    import alu_ctl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic             fill,
    input  logic [CNT_W-1:0] count,
    input  logic [7:0]       din_hi,
    input  logic [7:0]       din_lo,
    output logic [2:0]       alu_cmd,
    output logic [2:0]       alu_typeselect,
    output logic [7:0]       alu_inA,
    output logic             alu_sc_in,
    input  logic [7:0]       alu_rslt,
    input  logic             alu_sc_o,
    output logic             busy,
    output logic             done,
    output logic [7:0]       dout_hi,
    output logic [7:0]       dout_lo,
    output logic             cout
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_e       state_q;
    logic [7:0]       hi_q;
    logic [7:0]       lo_q;
    logic [7:0]       dout_hi_q;
    logic [7:0]       dout_lo_q;
    logic             dir_q;
    logic             fill_q;
    logic             carry_q;
    logic             cout_q;
    logic             done_q;
    logic             busy_q;
    logic [CNT_W-1:0] rem_q;

    // Sequencer FSM with the working operand, the counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            dout_hi_q <= 8'h00;
            dout_lo_q <= 8'h00;
            dir_q     <= 1'b0;
            fill_q    <= 1'b0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            rem_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        hi_q    <= din_hi;
                        lo_q    <= din_lo;
                        dir_q   <= dir;
                        fill_q  <= fill;
                        rem_q   <= count;
                        cout_q  <= 1'b0;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (count == '0) begin
                            // A zero shift completes at once with the operand unchanged.
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            dout_hi_q <= din_hi;
                            dout_lo_q <= din_lo;
                        end else begin
                            state_q <= ST_FIRST;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FIRST: begin
                    if (dir_q) begin
                        hi_q <= alu_rslt;
                    end else begin
                        lo_q <= alu_rslt;
                    end
                    carry_q <= alu_sc_o;
                    state_q <= ST_SECOND;
                end
                ST_SECOND: begin
                    if (dir_q) begin
                        lo_q <= alu_rslt;
                    end else begin
                        hi_q <= alu_rslt;
                    end
                    cout_q <= alu_sc_o;
                    if (rem_q != '0) begin
                        rem_q <= rem_q - CNT_ONE;
                    end else begin
                        rem_q <= '0;
                    end
                    if (rem_q <= CNT_ONE) begin
                        // Last step: publish the result, including the byte written this cycle.
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        dout_hi_q <= dir_q ? hi_q : alu_rslt;
                        dout_lo_q <= dir_q ? alu_rslt : lo_q;
                    end else begin
                        state_q <= ST_FIRST;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ALU drive, decoded only from registered state so that it holds steady for the whole cycle.
    always_comb begin
        alu_cmd        = ALU_NOP;
        alu_typeselect = 3'b000;
        alu_inA        = 8'h00;
        alu_sc_in      = 1'b0;
        case (state_q)
            ST_FIRST: begin
                alu_cmd        = ALU_SHIFT;
                alu_typeselect = dir_q ? (fill_q ? TS_SR1 : TS_SR0)
                                       : (fill_q ? TS_SL1 : TS_SL0);
                alu_inA        = dir_q ? hi_q : lo_q;
                alu_sc_in      = 1'b0;
            end
            ST_SECOND: begin
                alu_cmd        = ALU_SHIFT;
                alu_typeselect = dir_q ? TS_SRC : TS_SLC;
                alu_inA        = dir_q ? lo_q : hi_q;
                alu_sc_in      = carry_q;
            end
            default: begin
                alu_cmd        = ALU_NOP;
                alu_typeselect = 3'b000;
                alu_inA        = 8'h00;
                alu_sc_in      = 1'b0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dout_hi = dout_hi_q;
    assign dout_lo = dout_lo_q;
    assign cout    = cout_q;

endmodule
